// File: rtl/delay_meter_if.sv
// Handshake bundle for delay_meter: measurement controls in, results out.
interface delay_meter_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 arm;
  logic                 start;
  logic                 stop;
  logic                 busy;
  logic                 valid;
  logic                 timeout;
  logic [CNT_WIDTH-1:0] delay;
  logic [CNT_WIDTH-1:0] delay_min;
  logic [CNT_WIDTH-1:0] delay_max;

  // Stimulus side: drives the markers and arm, observes results.
  modport master (
    output arm, start, stop,
    input  busy, valid, timeout, delay, delay_min, delay_max
  );

  // Meter side.
  modport slave (
    input  arm, start, stop,
    output busy, valid, timeout, delay, delay_min, delay_max
  );
endinterface

// File: rtl/delay_meter.sv
// Path delay meter: counts cycles from a start marker to the matching stop
// marker, averages 2^AVG_LOG2 measurements per batch and reports the batch
// average together with its minimum and maximum. Measurements that reach
// TIMEOUT cycles abandon the batch.
module delay_meter #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1000,
  parameter int AVG_LOG2  = 2
) (
  input  logic         clk,
  input  logic         rst,
  delay_meter_if.slave bus
);

  localparam int ACC_W  = CNT_WIDTH + AVG_LOG2;
  localparam int BCNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [BCNT_W-1:0]    BATCH_C   = BCNT_W'(2 ** AVG_LOG2);

  typedef enum logic [1:0] {IDLE, WAIT_START, COUNT} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [ACC_W-1:0]     acc, acc_nxt;
  logic [BCNT_W-1:0]    bcnt, bcnt_nxt;
  logic [CNT_WIDTH-1:0] run_min, run_min_nxt;
  logic [CNT_WIDTH-1:0] run_max, run_max_nxt;
  logic [CNT_WIDTH-1:0] delay_q, delay_nxt;
  logic [CNT_WIDTH-1:0] min_q, min_nxt;
  logic [CNT_WIDTH-1:0] max_q, max_nxt;
  logic                 valid_q, valid_nxt;
  logic                 timeout_q, timeout_nxt;

  logic                 rec_en;
  logic [CNT_WIDTH-1:0] rec_val;
  logic [ACC_W-1:0]     acc_sum;
  logic [BCNT_W-1:0]    bcnt_sum;
  logic [CNT_WIDTH-1:0] min_upd;
  logic [CNT_WIDTH-1:0] max_upd;

  // Truncating batch average; the accumulator is sized so the sum never wraps.
  function automatic logic [CNT_WIDTH-1:0] batch_avg(input logic [ACC_W-1:0] sum);
    return CNT_WIDTH'(sum >> AVG_LOG2);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] umin(input logic [CNT_WIDTH-1:0] a,
                                                input logic [CNT_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] umax(input logic [CNT_WIDTH-1:0] a,
                                                input logic [CNT_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // A measurement taken in WAIT_START (start and stop together) is zero cycles.
  assign rec_val  = (state == COUNT) ? cnt : '0;
  assign acc_sum  = acc + ACC_W'(rec_val);
  assign bcnt_sum = bcnt + BCNT_W'(1);
  assign min_upd  = umin(run_min, rec_val);
  assign max_upd  = umax(run_max, rec_val);

  // Next-state and result logic; arm overrides every other event.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    acc_nxt     = acc;
    bcnt_nxt    = bcnt;
    run_min_nxt = run_min;
    run_max_nxt = run_max;
    delay_nxt   = delay_q;
    min_nxt     = min_q;
    max_nxt     = max_q;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    rec_en      = 1'b0;
    if (bus.arm) begin
      state_nxt   = WAIT_START;
      cnt_nxt     = '0;
      acc_nxt     = '0;
      bcnt_nxt    = '0;
      run_min_nxt = '1;
      run_max_nxt = '0;
    end else begin
      unique case (state)
        WAIT_START: begin
          if (bus.start) begin
            if (bus.stop) begin
              rec_en = 1'b1;
            end else begin
              state_nxt = COUNT;
              cnt_nxt   = CNT_WIDTH'(1);
            end
          end
        end
        COUNT: begin
          // Timeout is checked first so a stop on the limit cycle still times out.
          if (cnt == TIMEOUT_C) begin
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            acc_nxt     = '0;
            bcnt_nxt    = '0;
          end else if (bus.stop) begin
            rec_en = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
      if (rec_en) begin
        acc_nxt     = acc_sum;
        bcnt_nxt    = bcnt_sum;
        run_min_nxt = min_upd;
        run_max_nxt = max_upd;
        cnt_nxt     = '0;
        if (bcnt_sum == BATCH_C) begin
          state_nxt = IDLE;
          valid_nxt = 1'b1;
          delay_nxt = batch_avg(acc_sum);
          min_nxt   = min_upd;
          max_nxt   = max_upd;
        end else begin
          state_nxt = WAIT_START;
        end
      end
    end
  end

  // State, counters and published results; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      bcnt      <= '0;
      run_min   <= '1;
      run_max   <= '0;
      delay_q   <= '0;
      min_q     <= '0;
      max_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      bcnt      <= bcnt_nxt;
      run_min   <= run_min_nxt;
      run_max   <= run_max_nxt;
      delay_q   <= delay_nxt;
      min_q     <= min_nxt;
      max_q     <= max_nxt;
      valid_q   <= valid_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.delay     = delay_q;
  assign bus.delay_min = min_q;
  assign bus.delay_max = max_q;

endmodule

// File: tb/tb_delay_meter.sv
// Bench for delay_meter: two instances (4-sample and 1-sample averaging,
// TIMEOUT=20) driven by directed scenarios and random batches, checked
// against a transaction-level model of lags, sums and batch boundaries.
module tb_delay_meter;

  localparam int W   = 16;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic arm_v[2], start_v[2], stop_v[2];
  logic vld[2], tmo[2], bsy[2];
  logic [W-1:0] dly[2], dmin[2], dmax[2];

  delay_meter_if #(.CNT_WIDTH(W)) if_a ();
  delay_meter_if #(.CNT_WIDTH(W)) if_b ();

  assign if_a.arm = arm_v[0];  assign if_a.start = start_v[0];  assign if_a.stop = stop_v[0];
  assign if_b.arm = arm_v[1];  assign if_b.start = start_v[1];  assign if_b.stop = stop_v[1];
  assign vld[0] = if_a.valid;  assign tmo[0] = if_a.timeout;  assign bsy[0] = if_a.busy;
  assign vld[1] = if_b.valid;  assign tmo[1] = if_b.timeout;  assign bsy[1] = if_b.busy;
  assign dly[0] = if_a.delay;  assign dmin[0] = if_a.delay_min;  assign dmax[0] = if_a.delay_max;
  assign dly[1] = if_b.delay;  assign dmin[1] = if_b.delay_min;  assign dmax[1] = if_b.delay_max;

  delay_meter #(.CNT_WIDTH(W), .TIMEOUT(TMO), .AVG_LOG2(2)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  delay_meter #(.CNT_WIDTH(W), .TIMEOUT(TMO), .AVG_LOG2(0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance.
  int lg[2];
  int sum_m[2], cnt_m[2], mn_m[2], mx_m[2];
  int exp_d[2], exp_mn[2], exp_mx[2];
  bit active[2], ev[2], et[2];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_u%0d_valid", tag, d), int'(vld[d]), int'(ev[d]));
      chk($sformatf("%s_u%0d_timeout", tag, d), int'(tmo[d]), int'(et[d]));
      chk($sformatf("%s_u%0d_busy", tag, d), int'(bsy[d]), int'(active[d]));
      chk($sformatf("%s_u%0d_delay", tag, d), int'(dly[d]), exp_d[d]);
      chk($sformatf("%s_u%0d_min", tag, d), int'(dmin[d]), exp_mn[d]);
      chk($sformatf("%s_u%0d_max", tag, d), int'(dmax[d]), exp_mx[d]);
      ev[d] = 1'b0;
      et[d] = 1'b0;
    end
  endtask

  task automatic record(input int d, input int n);
    sum_m[d] += n;
    cnt_m[d]++;
    if (n < mn_m[d]) mn_m[d] = n;
    if (n > mx_m[d]) mx_m[d] = n;
    if (cnt_m[d] == (1 << lg[d])) begin
      ev[d]     = 1'b1;
      exp_d[d]  = sum_m[d] >> lg[d];
      exp_mn[d] = mn_m[d];
      exp_mx[d] = mx_m[d];
      active[d] = 1'b0;
    end
  endtask

  task automatic do_arm(input int d, input logic with_start, input logic with_stop);
    arm_v[d] = 1'b1;  start_v[d] = with_start;  stop_v[d] = with_stop;
    step();
    arm_v[d] = 1'b0;  start_v[d] = 1'b0;  stop_v[d] = 1'b0;
    active[d] = 1'b1;
    sum_m[d]  = 0;
    cnt_m[d]  = 0;
    mn_m[d]   = (1 << W) - 1;
    mx_m[d]   = 0;
    check_all("arm");
  endtask

  // Cycles outside a measurement: lone stops (and starts when idle) must be ignored.
  task automatic gap(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      stop_v[d]  = 1'(($urandom_range(0, 1)));
      start_v[d] = active[d] ? 1'b0 : 1'(($urandom_range(0, 1)));
      step();
      check_all("gap");
    end
    start_v[d] = 1'b0;
    stop_v[d]  = 1'b0;
  endtask

  // One start/stop pair with stop sampled lag cycles after start.
  task automatic measure(input int d, input int lag);
    start_v[d] = 1'b1;
    stop_v[d]  = (lag == 0);
    step();
    start_v[d] = 1'b0;
    stop_v[d]  = 1'b0;
    if (lag == 0) record(d, 0);
    check_all("start");
    for (int k = 1; k <= lag && k <= TMO; k++) begin
      stop_v[d]  = (k == lag);
      start_v[d] = 1'(($urandom_range(0, 1)));
      step();
      if (k == TMO) begin
        et[d]     = 1'b1;
        active[d] = 1'b0;
      end else if (k == lag) begin
        record(d, lag);
      end
      check_all("count");
    end
    start_v[d] = 1'b0;
    stop_v[d]  = 1'b0;
  endtask

  // Start a measurement, then re-arm (with a stop) when the counter reaches k.
  task automatic abort_at(input int d, input int k);
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
    check_all("ab_start");
    for (int j = 1; j < k; j++) begin
      step();
      check_all("ab_count");
    end
    do_arm(d, 1'b1, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lg[0] = 2;
    lg[1] = 0;
    for (int d = 0; d < 2; d++) begin
      arm_v[d] = 1'b0;  start_v[d] = 1'b0;  stop_v[d] = 1'b0;
      sum_m[d] = 0;  cnt_m[d] = 0;  mn_m[d] = 0;  mx_m[d] = 0;
      exp_d[d] = 0;  exp_mn[d] = 0;  exp_mx[d] = 0;
      active[d] = 1'b0;  ev[d] = 1'b0;  et[d] = 1'b0;
    end

    // Reset state, then release away from the clock edge.
    #2 rst = 1'b1;
    repeat (3) step();
    check_all("reset");
    rst = 1'b0;
    step();
    check_all("idle");

    // Single-sample meter: lag 5, then zero lag, then lag just under the limit.
    do_arm(1, 1'b0, 1'b0);
    gap(1, 8);
    measure(1, 5);
    gap(1, 3);
    do_arm(1, 1'b0, 1'b0);
    measure(1, 0);
    do_arm(1, 1'b0, 1'b0);
    measure(1, TMO - 1);

    // Four-sample batch: 3,4,6,8 -> 21>>2 = 5.
    do_arm(0, 1'b0, 1'b0);
    measure(0, 3);  gap(0, 2);
    measure(0, 4);  gap(0, 1);
    measure(0, 6);
    measure(0, 8);
    gap(0, 3);

    // Timeouts: no stop at all, and stop exactly on the limit cycle.
    do_arm(0, 1'b0, 1'b0);
    measure(0, 25);
    do_arm(0, 1'b0, 1'b0);
    measure(0, 2);
    measure(0, TMO);
    gap(0, 2);

    // Re-arm mid-measurement after two samples, then four lag-7 pairs.
    do_arm(0, 1'b0, 1'b0);
    measure(0, 2);
    measure(0, 9);
    abort_at(0, 4);
    for (int i = 0; i < 4; i++) measure(0, 7);

    // Re-arm on the very cycle that would otherwise time out.
    do_arm(1, 1'b0, 1'b0);
    abort_at(1, TMO);
    measure(1, 11);

    // Asynchronous reset in the middle of a count.
    do_arm(0, 1'b0, 1'b0);
    measure(0, 4);
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    check_all("pre_rst");
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      active[d] = 1'b0;  exp_d[d] = 0;  exp_mn[d] = 0;  exp_mx[d] = 0;
    end
    check_all("async_rst");
    #1 rst = 1'b0;
    stop_v[0] = 1'b1;
    step();
    stop_v[0] = 1'b0;
    check_all("post_rst");

    // Random batches on either instance.
    for (int it = 0; it < 40; it++) begin
      int d;
      d = int'($urandom_range(0, 1));
      do_arm(d, 1'b0, 1'b0);
      for (int g = 0; active[d] && g < 40; g++) begin
        gap(d, int'($urandom_range(0, 3)));
        if ($urandom_range(0, 9) == 0) abort_at(d, int'($urandom_range(1, TMO)));
        else measure(d, int'($urandom_range(0, 23)));
      end
      gap(d, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/delay_meter.md
DELAY_METER -- requirements
Module: delay_meter

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of delay/min/max results and the cycle counter.
REQ-002 Parameter TIMEOUT, default 1000, cycle count at which a measurement is abandonded; legal range 1..2^CNT_WIDTH-1.
REQ-003 Parameter AVG_LOG2, default 2, number of measurements averaged per result = 2^AVG_LOG2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 arm  input  1  level sampled each cycle; high starts a new measurement batch.
REQ-007 start  input  1  reference marker strobe (signal entering the path under test).
REQ-008 stop  input  1  delayed marker strobe (same marker leaving the path under test).
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 valid  output  1  one-cycle pulse; delay/delay_min/delay_max updated on the same edge.
REQ-011 delay  output  CNT_WIDTH  averaged delay in clock cycles.
REQ-012 delay_min  output  CNT_WIDTH  smallest single measurement in the batch.
REQ-013 delay_max  output  CNT_WIDTH  largest single measurement in the batch.
REQ-014 timeout  output  1  one-cycle pulse when a measurement is abandoned.

Function
REQ-015 FSM states: IDLE, WAIT_START, COUNT.
REQ-016 Batch init on any edge sampling arm=1 (any state, including mid-measurement abort): accumulator=0, batch count=0, running min=all ones, running max=0, next state WAIT_START.
REQ-017 WAIT_START: start=1 -> COUNT with counter=1; start and stop both 1 in same cycle -> measurement of 0 recorded, remain in or leave WAIT_START per REQ-020.
REQ-018 COUNT: counter increments by 1 each cycle; start ignored; stop sampled with counter=N records measurement N (N cycles between start sample and stop sample).
REQ-019 Recording: accumulator += N (accumulator width CNT_WIDTH+AVG_LOG2, never overflows), running min/max updated with N, batch count += 1.
REQ-020 Batch count below 2^AVG_LOG2 after recording -> WAIT_START; equal -> IDLE and, on that same edge, valid=1, delay=(accumulator+N)>>AVG_LOG2 (truncating), delay_min/delay_max = updated min/max.
REQ-021 Timeout: in COUNT, counter==TIMEOUT with stop=0, or stop=1 with counter==TIMEOUT (timeout wins) -> timeout=1 for one cycle, state IDLE, delay/delay_min/delay_max/valid unchanged, partial batch discarded.
REQ-022 arm=1 has priority over start, stop and timeout in the same cycle.
REQ-023 IDLE: start and stop ignored; outputs hold last result indefinitely.
REQ-024 valid and timeout never high in the same cycle; each is high for exactly one cycle per event.
REQ-025 Latency: valid asserted on the clock edge that samples the final stop; no additional pipeline stage.

Reset
REQ-026 rst=1 forces immediately, independent of clk: state IDLE, busy=0, valid=0, timeout=0, delay=0, delay_min=0, delay_max=0, counter/accumulator/batch count=0.
REQ-027 rst asserted mid-batch discards all partial results; first edge after deassertion behaves as IDLE.

Verification
REQ-028 AVG_LOG2=0: arm, start at cycle 10, stop at cycle 15 -> valid=1 on edge sampling stop, delay=5, min=max=5, busy then 0.
REQ-029 AVG_LOG2=2: four start/stop pairs with lags 3,4,6,8 -> single valid after fourth stop, delay=5 (21>>2), min=3, max=8, no valid earlier.
REQ-030 TIMEOUT=20: start, no stop -> timeout pulse 20 cycles after start, valid=0, previous delay retained; stop at lag 20 also -> timeout, not valid.
REQ-031 start and stop same cycle, AVG_LOG2=0 -> valid with delay=0, min=max=0.
REQ-032 arm mid-COUNT after two of four measurements -> batch restarts; next four pairs (lag 7 each) give delay=7, min=max=7.
REQ-033 rst pulse mid-COUNT, asynchronous to clk -> all outputs 0 immediately; stop afterwards produces no valid.
